serial_word_feeder: RTL and testbench

Upstream feeder for the sequence detector: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and emits them MSB-first as a one-bit-per-clock serial stream with a qualifying valid. Its `serial_out` drives the detector's serial input. Back-to-back words are emitted with no gap cycles, so detector test streams and live traffic are continuous.

---
 rtl/serial_word_feeder_pkg.sv | 20 ++
 rtl/serial_word_feeder_if.sv | 11 +
 rtl/serial_word_feeder_fifo.sv | 52 +++++
 rtl/serial_word_feeder.sv | 81 ++++++++
 tb/tb_serial_word_feeder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_feeder_pkg.sv
// Shared types and size helpers for the serial word feeder and its FIFO.
package feeder_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  localparam int FEEDER_WORD_W     = 5;
  localparam int FEEDER_FIFO_DEPTH = 4;

  function automatic int ptrWidth(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FEEDER_PTR_W   = ptrWidth(FEEDER_FIFO_DEPTH);
  localparam int FEEDER_LEVEL_W = levelWidth(FEEDER_FIFO_DEPTH);

endpackage

// File: rtl/serial_word_feeder_if.sv
// Parallel word handshake into the feeder: producer is master, feeder is slave.
interface serial_word_feeder_if #(
  parameter int WORD_W = feeder_pkg::FEEDER_WORD_W
);
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_word, output in_valid, input in_ready);
  modport slave  (input in_word, input in_valid, output in_ready);
endinterface

// File: rtl/serial_word_feeder_fifo.sv
// Synchronous FIFO with level output; reads are from the head entry combinationally.
module sync_fifo
  import feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PTR_W = ptrWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/serial_word_feeder.sv
// Buffers parallel words and emits them MSB-first, one bit per enabled clock, gap-free.
module serial_word_feeder
  import feeder_pkg::*;
#(
  parameter int WORD_W     = FEEDER_WORD_W,
  parameter int FIFO_DEPTH = FEEDER_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  serial_word_feeder_if.slave         feedIf,
  input  logic                        enable,
  output logic                        serial_out,
  output logic                        serial_valid,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 words_sent
);
  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] DONE_IDX = IDX_W'(WORD_W);
  localparam logic [IDX_W-1:0] LSB_IDX  = IDX_W'(WORD_W - 1);

  state_e            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [IDX_W-1:0]  bitIdx_q;
  logic              serialOut_q, serialValid_q;
  logic [15:0]       wordsSent_q;
  logic              fifoFull, fifoEmpty, fifoPop;
  logic [WORD_W-1:0] fifoData;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (feedIf.in_valid),
    .pop_i   (fifoPop),
    .wdata_i (feedIf.in_word),
    .rdata_o (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifo_level)
  );

  // bitIdx_q == DONE_IDX marks the cycle after the LSB, where the next word may chain in.
  assign fifoPop = enable && !fifoEmpty &&
                   ((state_q == S_IDLE) || (bitIdx_q == DONE_IDX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bitIdx_q      <= '0;
      serialOut_q   <= 1'b0;
      serialValid_q <= 1'b0;
      wordsSent_q   <= '0;
    end else begin
      serialValid_q <= 1'b0;
      if (fifoPop) begin
        serialOut_q   <= fifoData[WORD_W-1];
        shift_q       <= fifoData << 1;
        bitIdx_q      <= IDX_W'(1);
        serialValid_q <= 1'b1;
        state_q       <= S_SHIFT;
      end else if (state_q == S_SHIFT) begin
        if (bitIdx_q == DONE_IDX) begin
          state_q <= S_IDLE;
        end else if (enable) begin
          serialOut_q   <= shift_q[WORD_W-1];
          shift_q       <= shift_q << 1;
          bitIdx_q      <= bitIdx_q + 1'b1;
          serialValid_q <= 1'b1;
          if (bitIdx_q == LSB_IDX) wordsSent_q <= wordsSent_q + 16'd1;
        end
      end
    end
  end

  assign feedIf.in_ready = !fifoFull;
  assign serial_out      = serialOut_q;
  assign serial_valid    = serialValid_q;
  assign busy            = (state_q == S_SHIFT) || !fifoEmpty;
  assign words_sent      = wordsSent_q;
endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed self-checking bench for serial_word_feeder with WORD_W=5, FIFO_DEPTH=4.
module tb_serial_word_feeder;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        serial_out, serial_valid, busy;
  logic [2:0]  fifo_level;
  logic [15:0] words_sent;
  int          checkCount = 0;
  int          passCount  = 0;
  int          gaps;

  serial_word_feeder_if #(.WORD_W(5)) feedIf ();

  serial_word_feeder #(.WORD_W(5), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .feedIf       (feedIf),
    .enable       (enable),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .words_sent   (words_sent)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [4:0] word, input logic valid, input logic en);
    feedIf.in_word  = word;
    feedIf.in_valid = valid;
    enable          = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(5'd0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  // Gaps are only counted once the first bit of the stream has appeared.
  task automatic expectStream(input logic [63:0] bits, input int n, input int maxCycles,
                              input string tag, output int gapCount);
    int got = 0;
    int cyc = 0;
    bit started = 1'b0;
    gapCount = 0;
    while (got < n && cyc < maxCycles) begin
      step();
      cyc++;
      if (serial_valid) begin
        checkOutput($sformatf("%s bit%0d", tag, got), {31'd0, serial_out}, {31'd0, bits[n-1-got]});
        got++;
        started = 1'b1;
      end else if (started) begin
        gapCount++;
      end
    end
    if (got < n) checkOutput({tag, " timeout"}, got, n);
  endtask

  initial begin
    logic [4:0] single;
    resetDut();
    checkOutput("reset serial_out", {31'd0, serial_out}, 32'd0);
    checkOutput("reset serial_valid", {31'd0, serial_valid}, 32'd0);
    checkOutput("reset fifo_level", {29'd0, fifo_level}, 32'd0);
    checkOutput("reset words_sent", {16'd0, words_sent}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset in_ready", {31'd0, feedIf.in_ready}, 32'd1);

    $display("[TB] single word 10001");
    single = 5'b10001;
    step();
    applyStimulus(5'b10001, 1'b1, 1'b1);
    step();
    applyStimulus(5'b10001, 1'b0, 1'b1);
    checkOutput("push level", {29'd0, fifo_level}, 32'd1);
    checkOutput("no bypass valid", {31'd0, serial_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput($sformatf("single valid%0d", k), {31'd0, serial_valid}, 32'd1);
      checkOutput($sformatf("single bit%0d", k), {31'd0, serial_out}, {31'd0, single[4-k]});
      if (k == 3) checkOutput("single count early", {16'd0, words_sent}, 32'd0);
    end
    checkOutput("single count", {16'd0, words_sent}, 32'd1);
    checkOutput("single busy last", {31'd0, busy}, 32'd1);
    step();
    checkOutput("single busy after", {31'd0, busy}, 32'd0);
    checkOutput("single valid after", {31'd0, serial_valid}, 32'd0);

    $display("[TB] back-to-back words");
    resetDut();
    fork
      begin
        applyStimulus(5'b01110, 1'b1, 1'b1);
        step();
        applyStimulus(5'b10101, 1'b1, 1'b1);
        step();
        applyStimulus(5'b11110, 1'b1, 1'b1);
        step();
        applyStimulus(5'b00000, 1'b0, 1'b1);
      end
      expectStream(64'b011101010111110, 15, 40, "b2b", gaps);
    join
    checkOutput("b2b gaps", gaps, 0);
    checkOutput("b2b count", {16'd0, words_sent}, 32'd3);

    $display("[TB] full FIFO with enable low");
    resetDut();
    applyStimulus(5'b11000, 1'b1, 1'b0);
    step();
    applyStimulus(5'b00111, 1'b1, 1'b0);
    step();
    applyStimulus(5'b10110, 1'b1, 1'b0);
    step();
    checkOutput("fill ready3", {31'd0, feedIf.in_ready}, 32'd1);
    applyStimulus(5'b01001, 1'b1, 1'b0);
    step();
    checkOutput("fill level4", {29'd0, fifo_level}, 32'd4);
    checkOutput("fill ready4", {31'd0, feedIf.in_ready}, 32'd0);
    applyStimulus(5'b11011, 1'b1, 1'b0);
    step();
    step();
    checkOutput("fill held level", {29'd0, fifo_level}, 32'd4);
    checkOutput("fill held valid", {31'd0, serial_valid}, 32'd0);
    applyStimulus(5'b11011, 1'b1, 1'b1);
    fork
      begin
        step();
        checkOutput("pop ready", {31'd0, feedIf.in_ready}, 32'd1);
        checkOutput("pop level", {29'd0, fifo_level}, 32'd3);
        step();
        applyStimulus(5'b00000, 1'b0, 1'b1);
        checkOutput("fifth push level", {29'd0, fifo_level}, 32'd4);
      end
      expectStream({5'b11000, 5'b00111, 5'b10110, 5'b01001, 5'b11011}, 25, 60, "full", gaps);
    join
    checkOutput("full gaps", gaps, 0);
    checkOutput("full count", {16'd0, words_sent}, 32'd5);

    $display("[TB] pause mid-word");
    resetDut();
    applyStimulus(5'b10101, 1'b1, 1'b1);
    step();
    applyStimulus(5'b00000, 1'b0, 1'b1);
    step();
    checkOutput("pause bit0", {30'd0, serial_valid, serial_out}, 32'b11);
    step();
    checkOutput("pause bit1", {30'd0, serial_valid, serial_out}, 32'b10);
    enable = 1'b0;
    step();
    checkOutput("pause hold1", {30'd0, serial_valid, serial_out}, 32'b00);
    step();
    checkOutput("pause hold2", {30'd0, serial_valid, serial_out}, 32'b00);
    enable = 1'b1;
    step();
    checkOutput("pause bit2", {30'd0, serial_valid, serial_out}, 32'b11);
    step();
    checkOutput("pause bit3", {30'd0, serial_valid, serial_out}, 32'b10);
    step();
    checkOutput("pause bit4", {30'd0, serial_valid, serial_out}, 32'b11);
    checkOutput("pause count", {16'd0, words_sent}, 32'd1);

    $display("[TB] reset mid-word");
    resetDut();
    applyStimulus(5'b11100, 1'b1, 1'b1);
    step();
    applyStimulus(5'b10011, 1'b1, 1'b1);
    step();
    checkOutput("rst bit0", {30'd0, serial_valid, serial_out}, 32'b11);
    applyStimulus(5'b01010, 1'b1, 1'b1);
    step();
    applyStimulus(5'b00000, 1'b0, 1'b1);
    step();
    checkOutput("rst queued", {29'd0, fifo_level}, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst serial_out", {31'd0, serial_out}, 32'd0);
    checkOutput("rst serial_valid", {31'd0, serial_valid}, 32'd0);
    checkOutput("rst fifo_level", {29'd0, fifo_level}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst in_ready", {31'd0, feedIf.in_ready}, 32'd1);
    step();
    checkOutput("rst no output", {31'd0, serial_valid}, 32'd0);
    applyStimulus(5'b01101, 1'b1, 1'b1);
    step();
    applyStimulus(5'b00000, 1'b0, 1'b1);
    expectStream(64'b01101, 5, 20, "fresh", gaps);
    checkOutput("fresh count", {16'd0, words_sent}, 32'd1);
    step();
    checkOutput("fresh drained", {29'd0, fifo_level}, 32'd0);

    $display("[TB] words_sent wrap");
    resetDut();
    dut.wordsSent_q = 16'hFFFE;
    applyStimulus(5'b10010, 1'b1, 1'b0);
    step();
    applyStimulus(5'b01011, 1'b1, 1'b0);
    step();
    applyStimulus(5'b00000, 1'b0, 1'b1);
    expectStream(64'b10010, 5, 20, "wrapA", gaps);
    checkOutput("wrap ffff", {16'd0, words_sent}, 32'h0000FFFF);
    expectStream(64'b01011, 5, 20, "wrapB", gaps);
    checkOutput("wrap gaps", gaps, 0);
    checkOutput("wrap zero", {16'd0, words_sent}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
